// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port 128x9 BSRAM: zero-fills the array after reset,
// then grants one round-robin access per cycle. Optional tie-lock streaks via SRAM_ARB_LOCK_EN.
module sram_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 9
`ifdef SRAM_ARB_LOCK_EN
    ,
    parameter int LOCK_MAX = 4
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
`ifdef SRAM_ARB_LOCK_EN
    input  logic              a_lock,
    input  logic              b_lock,
`endif
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              sram_ce,
    output logic              sram_wre,
    output logic [ADDR_W-1:0] sram_ad,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ad_q;
    logic              rr_last_q, rr_last_d;   // 0 = A granted last, 1 = B
    logic              a_rvalid_q, b_rvalid_q;
    logic              init_done_q;
    logic              tie_to_a;

`ifdef SRAM_ARB_LOCK_EN
    localparam int STREAK_W = $clog2(LOCK_MAX + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;

    // A non-zero streak means the rr_last port was granted in the previous cycle.
    always_comb begin
        tie_to_a = rr_last_q;
        if ((streak_q != '0) && (streak_q < STREAK_W'(LOCK_MAX)) && (rr_last_q ? b_lock : a_lock))
            tie_to_a = ~rr_last_q;
    end

    always_comb begin
        streak_d = '0;
        if (a_gnt || b_gnt) begin
            if ((b_gnt == rr_last_q) && (streak_q != '0))
                streak_d = (streak_q < STREAK_W'(LOCK_MAX)) ? streak_q + 1'b1 : streak_q;
            else
                streak_d = STREAK_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            streak_q <= '0;
        else
            streak_q <= streak_d;
    end
`else
    assign tie_to_a = rr_last_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        sram_ce   = 1'b1;
        sram_wre  = 1'b0;
        sram_ad   = ad_q;
        sram_din  = '0;
        case (state_q)
            ST_INIT: begin
                sram_wre = 1'b1;
                sram_ad  = cnt_q;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!reset) begin
                    if (a_req && b_req) begin
                        a_gnt = tie_to_a;
                        b_gnt = ~tie_to_a;
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
                if (a_gnt) begin
                    sram_wre  = a_we;
                    sram_ad   = a_addr;
                    sram_din  = a_wdata;
                    rr_last_d = 1'b0;
                end else if (b_gnt) begin
                    sram_wre  = b_we;
                    sram_ad   = b_addr;
                    sram_din  = b_wdata;
                    rr_last_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ad_q        <= '0;
            rr_last_q   <= 1'b1;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ad_q        <= sram_ad;
            rr_last_q   <= rr_last_d;
            a_rvalid_q  <= a_gnt & ~a_we;
            b_rvalid_q  <= b_gnt & ~b_we;
            init_done_q <= (state_q == ST_RUN);
        end
    end

    // Bypass-mode SRAM already presents registered read data one cycle after the access.
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = sram_dout;
    assign b_rdata   = sram_dout;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural bypass-mode SRAM; lock test under SRAM_ARB_LOCK_EN.
module tb_sram_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       a_req, a_we, b_req, b_we;
    logic [6:0] a_addr, b_addr;
    logic [8:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [8:0] a_rdata, b_rdata;
    logic       sram_ce, sram_wre;
    logic [6:0] sram_ad;
    logic [8:0] sram_din;
    logic [8:0] sram_dout;
    logic       init_done;
`ifdef SRAM_ARB_LOCK_EN
    logic       a_lock, b_lock;
`endif

    int checks = 0;
    int failures = 0;

    logic [8:0] mem [0:127];

    always #5 clock = ~clock;

    sram_arbiter dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
`ifdef SRAM_ARB_LOCK_EN
        .a_lock(a_lock), .b_lock(b_lock),
`endif
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_ce(sram_ce), .sram_wre(sram_wre), .sram_ad(sram_ad),
        .sram_din(sram_din), .sram_dout(sram_dout), .init_done(init_done)
    );

    // Single-port BSRAM, bypass mode: writes also appear on dout.
    always @(posedge clock) begin
        if (sram_ce) begin
            if (sram_wre) begin
                mem[sram_ad] <= sram_din;
                sram_dout    <= sram_din;
            end else begin
                sram_dout <= mem[sram_ad];
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && (a_gnt || b_gnt))
            $display("txn t=%0t port=%s we=%0d addr=%0h wdata=%0h", $time,
                     a_gnt ? "A" : "B", sram_wre, sram_ad, sram_din);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_release();
        reset = 1'b1;
        tick();
        tick();
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_init_done", init_done, 0);
        reset = 1'b0;
    endtask

    // Requests are held throughout the fill to show they are ignored.
    task automatic fill_sweep();
        a_req = 1'b1; a_we = 1'b0;
        b_req = 1'b1; b_we = 1'b0;
        for (int i = 0; i < 128; i++) begin
            #1;
            check("fill_ad", sram_ad, i);
            check("fill_wre", sram_wre, 1);
            check("fill_din", sram_din, 0);
            check("fill_gnt", {a_gnt, b_gnt}, 0);
            check("fill_done", init_done, 0);
            if (i == 127) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            tick();
        end
        #1;
        check("c128_done", init_done, 0);
        check("c128_wre", sram_wre, 0);
        tick();
        check("c129_done", init_done, 1);
        tick();
    endtask

    bit [6:0] pat_ag, pat_bg, pat_ar, pat_br;
`ifdef SRAM_ARB_LOCK_EN
    bit [9:0] pat_lock;
`endif

    initial begin
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
`ifdef SRAM_ARB_LOCK_EN
        a_lock = 0; b_lock = 0;
`endif
        for (int i = 0; i < 128; i++) mem[i] = 9'h1FF;

        reset_release();
        fill_sweep();

        // Zero-fill check at 0x55
        a_req = 1; a_we = 0; a_addr = 7'h55;
        #1;
        check("rd55_gnt", a_gnt, 1);
        check("rd55_ad", sram_ad, 'h55);
        tick();
        a_req = 0;
        #1;
        check("rd55_rvalid", a_rvalid, 1);
        check("rd55_rdata", a_rdata, 0);
        tick();

        // Write then read address 3
        a_req = 1; a_we = 1; a_addr = 7'd3; a_wdata = 9'h1A5;
        #1;
        check("wr3_gnt", a_gnt, 1);
        check("wr3_wre", sram_wre, 1);
        check("wr3_din", sram_din, 'h1A5);
        tick();
        a_we = 0;
        #1;
        check("rd3_gnt", a_gnt, 1);
        check("wr3_no_rvalid", a_rvalid, 0);
        tick();
        a_req = 0;
        #1;
        check("rd3_rvalid", a_rvalid, 1);
        check("rd3_rdata", a_rdata, 'h1A5);
        check("rd3_b_rvalid", b_rvalid, 0);
        check("idle_ad_hold", sram_ad, 3);
        check("idle_wre", sram_wre, 0);
        check("idle_ce", sram_ce, 1);
        tick();

        // Seed addresses 1 and 2; B last leaves rr_last = B
        a_req = 1; a_we = 1; a_addr = 7'd1; a_wdata = 9'h0A1;
        #1;
        check("wr1_gnt", a_gnt, 1);
        tick();
        a_req = 0;
        b_req = 1; b_we = 1; b_addr = 7'd2; b_wdata = 9'h0B2;
        #1;
        check("wr2_gnt", b_gnt, 1);
        tick();

        // Both reading for 6 cycles: A,B,A,B,A,B
        pat_ag = 7'b0010101; pat_bg = 7'b0101010;
        pat_ar = 7'b0101010; pat_br = 7'b1010100;
        a_req = 1; a_we = 0; b_we = 0;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin
                a_req = 0;
                b_req = 0;
            end
            #1;
            check("rr_a_gnt", a_gnt, pat_ag[k]);
            check("rr_b_gnt", b_gnt, pat_bg[k]);
            check("rr_a_rvalid", a_rvalid, pat_ar[k]);
            check("rr_b_rvalid", b_rvalid, pat_br[k]);
            if (a_rvalid) check("rr_a_rdata", a_rdata, 'h0A1);
            if (b_rvalid) check("rr_b_rdata", b_rdata, 'h0B2);
            tick();
        end

        // B alone three times, then a tie goes to A
        b_req = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bonly_b_gnt", b_gnt, 1);
            check("bonly_a_gnt", a_gnt, 0);
            tick();
        end
        a_req = 1;
        #1;
        check("tie_a_gnt", a_gnt, 1);
        check("tie_b_gnt", b_gnt, 0);
        check("tie_b_rvalid", b_rvalid, 1);
        check("tie_b_rdata", b_rdata, 'h0B2);
        tick();
        a_req = 0; b_req = 0;
        #1;
        check("tie_a_rvalid", a_rvalid, 1);
        check("tie_a_rdata", a_rdata, 'h0A1);
        tick();

`ifdef SRAM_ARB_LOCK_EN
        // Put rr_last on B, then A streams locked ties: A,A,A,A,B,A,A,A,A,B
        b_req = 1; b_we = 1; b_addr = 7'd5; b_wdata = 9'h055;
        #1;
        check("lk_seed_gnt", b_gnt, 1);
        tick();
        pat_lock = 10'b0111101111;
        b_we = 0; a_req = 1; a_we = 0; a_lock = 1; b_lock = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("lock_a_gnt", a_gnt, pat_lock[k]);
            check("lock_b_gnt", b_gnt, !pat_lock[k]);
            tick();
        end
        a_req = 0; b_req = 0; a_lock = 0;
        tick();
`endif

        // Reset at init counter 40 restarts the fill
        reset_release();
        for (int i = 0; i < 40; i++) tick();
        #1;
        check("mid_ad40", sram_ad, 40);
        check("mid_done", init_done, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fill_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
